// File: rtl/lsu_pkg.sv
// Shared configuration for the load/store unit: widths, flag codes, FSM
// encoding and the misalignment rule used at request accept.
package lsu_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned XREG_ADDRWIDTH = 5;
  localparam int unsigned LSU_TIMEOUT    = 255;

  localparam logic [4:0] NO_LOAD = 5'b00000;
  localparam logic [4:0] LOAD_B  = 5'b00001;
  localparam logic [4:0] LOAD_H  = 5'b00010;
  localparam logic [4:0] LOAD_W  = 5'b00100;
  localparam logic [4:0] LOAD_BU = 5'b01000;
  localparam logic [4:0] LOAD_HU = 5'b10000;

  localparam logic [3:0] NO_STORE = 4'b0000;
  localparam logic [3:0] STORE_B  = 4'b0001;
  localparam logic [3:0] STORE_H  = 4'b0010;
  localparam logic [3:0] STORE_W  = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // store_flag is expected to already be cleared when a load is present.
  function automatic logic is_misaligned(input logic [4:0] load_flag,
                                         input logic [3:0] store_flag,
                                         input logic [1:0] addr_lo);
    logic half;
    logic word;
    half = (load_flag == LOAD_H) || (load_flag == LOAD_HU) || (store_flag == STORE_H);
    word = (load_flag == LOAD_W) || (store_flag == STORE_W);
    return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load data extraction
// with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      addr_lo_i,
  input  logic [4:0]      load_flag_i,
  input  logic [3:0]      store_flag_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [31:0]     rdata_i,
  output logic [3:0]      wstrb_o,
  output logic [31:0]     wdata_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    wstrb_o = '0;
    wdata_o = '0;
    case (store_flag_i)
      STORE_B: begin
        wdata_o = {4{store_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      STORE_H: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      STORE_W: begin
        wdata_o = store_data_i[31:0];
        wstrb_o = '1;
      end
      default: ;
    endcase
  end

  // Word loads are always aligned here, so the shift is zero for them.
  always_comb begin
    shifted     = rdata_i >> {addr_lo_i, 3'b000};
    load_data_o = '0;
    case (load_flag_i)
      LOAD_B:  load_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LOAD_BU: load_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LOAD_H:  load_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LOAD_HU: load_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LOAD_W:  load_data_o = XLEN'(shifted);
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one op at a time, issues at most one dmem access
// with an ack timeout, and returns a one-cycle writeback pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_in,
  output logic                      req_ready_out,
  input  logic [XLEN-1:0]           addr_in,
  input  logic [4:0]                load_flag_in,
  input  logic [3:0]                store_flag_in,
  input  logic [XLEN-1:0]           store_data_in,
  input  logic                      rd_en_in,
  input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
  output logic                      dmem_req_out,
  output logic                      dmem_we_out,
  output logic [31:0]               dmem_addr_out,
  output logic [3:0]                dmem_wstrb_out,
  output logic [31:0]               dmem_wdata_out,
  input  logic                      dmem_ack_in,
  input  logic [31:0]               dmem_rdata_in,
  output logic                      wb_valid_out,
  output logic                      rd_en_out,
  output logic [XREG_ADDRWIDTH-1:0] rd_addr_out,
  output logic [XLEN-1:0]           rd_data_out,
  output logic                      misalign_out,
  output logic                      bus_err_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]           addr_q, addr_d;
  logic [4:0]                load_q, load_d;
  logic [3:0]                store_q, store_d;
  logic [XLEN-1:0]           data_q, data_d;
  logic                      rd_en_q, rd_en_d;
  logic [XREG_ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                      misalign_q, misalign_d;
  logic                      err_q, err_d;
  logic [31:0]               rdata_q, rdata_d;

  logic [3:0]      store_eff;
  logic            misalign_in;
  logic [3:0]      wstrb;
  logic [31:0]     wdata;
  logic [XLEN-1:0] load_data;

  // A load wins over a simultaneous store; the store is dropped at capture.
  assign store_eff   = (load_flag_in != NO_LOAD) ? NO_STORE : store_flag_in;
  assign misalign_in = is_misaligned(load_flag_in, store_eff, addr_in[1:0]);

  lsu_align u_align (
    .addr_lo_i    (addr_q[1:0]),
    .load_flag_i  (load_q),
    .store_flag_i (store_q),
    .store_data_i (data_q),
    .rdata_i      (rdata_q),
    .wstrb_o      (wstrb),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    load_d     = load_q;
    store_d    = store_q;
    data_d     = data_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    misalign_d = misalign_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          addr_d     = addr_in;
          load_d     = load_flag_in;
          store_d    = store_eff;
          data_d     = store_data_in;
          rd_en_d    = rd_en_in;
          rd_addr_d  = rd_addr_in;
          misalign_d = misalign_in;
          err_d      = 1'b0;
          rdata_d    = '0;
          cnt_d      = '0;
          if (((load_flag_in == NO_LOAD) && (store_eff == NO_STORE)) || misalign_in) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_ack_in) begin
          if (load_q != NO_LOAD) rdata_d = dmem_rdata_in;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      load_q     <= '0;
      store_q    <= '0;
      data_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      load_q     <= load_d;
      store_q    <= store_d;
      data_q     <= data_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  logic in_req;
  logic in_resp;
  logic is_store;
  logic fault;

  // Outputs decode from state so an asynchronous reset clears them at once.
  always_comb begin
    in_req         = (state_q == ST_REQ);
    in_resp        = (state_q == ST_RESP);
    is_store       = (store_q != NO_STORE);
    fault          = misalign_q || err_q;
    req_ready_out  = (state_q == ST_IDLE);
    dmem_req_out   = in_req;
    dmem_we_out    = in_req && is_store;
    dmem_addr_out  = in_req ? {addr_q[31:2], 2'b00} : '0;
    dmem_wstrb_out = in_req ? wstrb : '0;
    dmem_wdata_out = in_req ? wdata : '0;
    wb_valid_out   = in_resp;
    rd_en_out      = in_resp && rd_en_q && !is_store && !fault;
    rd_addr_out    = in_resp ? rd_addr_q : '0;
    misalign_out   = in_resp && misalign_q;
    bus_err_out    = in_resp && err_q;
    rd_data_out    = '0;
    if (in_resp && !fault && !is_store) begin
      rd_data_out = (load_q != NO_LOAD) ? load_data : addr_q;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed vectors push expected dmem requests and
// writebacks; a negedge monitor pops and compares when the DUT presents them.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [31:0] addr_in = '0;
  logic [4:0]  load_flag_in = '0;
  logic [3:0]  store_flag_in = '0;
  logic [31:0] store_data_in = '0;
  logic        rd_en_in = 1'b0;
  logic [4:0]  rd_addr_in = '0;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [3:0]  dmem_wstrb_out;
  logic [31:0] dmem_wdata_out;
  logic        dmem_ack_in = 1'b0;
  logic [31:0] dmem_rdata_in = '0;
  logic        wb_valid_out;
  logic        rd_en_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data_out;
  logic        misalign_out;
  logic        bus_err_out;

  lsu #(.TIMEOUT(255)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .addr_in        (addr_in),
    .load_flag_in   (load_flag_in),
    .store_flag_in  (store_flag_in),
    .store_data_in  (store_data_in),
    .rd_en_in       (rd_en_in),
    .rd_addr_in     (rd_addr_in),
    .dmem_req_out   (dmem_req_out),
    .dmem_we_out    (dmem_we_out),
    .dmem_addr_out  (dmem_addr_out),
    .dmem_wstrb_out (dmem_wstrb_out),
    .dmem_wdata_out (dmem_wdata_out),
    .dmem_ack_in    (dmem_ack_in),
    .dmem_rdata_in  (dmem_rdata_in),
    .wb_valid_out   (wb_valid_out),
    .rd_en_out      (rd_en_out),
    .rd_addr_out    (rd_addr_out),
    .rd_data_out    (rd_data_out),
    .misalign_out   (misalign_out),
    .bus_err_out    (bus_err_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          len;
  } dmem_exp_t;

  typedef struct {
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        mis;
    logic        err;
  } wb_exp_t;

  dmem_exp_t exp_dmem[$];
  wb_exp_t   exp_wb[$];

  typedef struct {
    logic [4:0]  ld;
    logic [3:0]  st;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd_en;
    logic [4:0]  rd_addr;
    int          ack_dly;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_daddr;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    int          exp_len;
    logic        exp_rd_en;
    logic [31:0] exp_rd_data;
    logic        exp_mis;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  // Memory responder: ack after ack_delay extra REQ cycles (-1 = never).
  int          ack_delay = -1;
  int          req_cycles = 0;
  logic [31:0] mem_rdata = '0;
  logic        ack_force = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (ack_force) begin
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = 32'hDEAD_0000;
      end else if (dmem_req_out) begin
        dmem_ack_in   = (req_cycles == ack_delay);
        dmem_rdata_in = (req_cycles == ack_delay) ? mem_rdata : 32'h0;
        req_cycles++;
      end else begin
        dmem_ack_in   = 1'b0;
        dmem_rdata_in = 32'h0;
        req_cycles    = 0;
      end
    end
  end

  // Monitor
  logic      req_prev = 1'b0;
  logic      wb_prev  = 1'b0;
  int        req_len  = 0;
  logic      have_cur = 1'b0;
  dmem_exp_t cur;
  wb_exp_t   w;

  initial begin
    forever begin
      @(negedge clk);
      if (dmem_req_out && !req_prev) begin
        req_len = 1;
        if (exp_dmem.size() == 0) begin
          total++; bad++; have_cur = 1'b0;
          $display("FAIL unexpected_dmem_req: got addr=0x%08h want no request", dmem_addr_out);
        end else begin
          cur = exp_dmem.pop_front();
          have_cur = 1'b1;
        end
      end else if (dmem_req_out) begin
        req_len++;
      end
      if (dmem_req_out && have_cur) begin
        check("dmem_we",    {31'b0, dmem_we_out},    {31'b0, cur.we});
        check("dmem_addr",  dmem_addr_out,           cur.addr);
        check("dmem_wstrb", {28'b0, dmem_wstrb_out}, {28'b0, cur.wstrb});
        check("dmem_wdata", dmem_wdata_out,          cur.wdata);
      end
      if (!dmem_req_out && req_prev && have_cur) begin
        check("dmem_req_len", req_len, cur.len);
        have_cur = 1'b0;
      end
      if (wb_valid_out) begin
        check("wb_single_pulse", {31'b0, wb_prev}, 32'd0);
        if (exp_wb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb: got rd_data=0x%08h want no writeback", rd_data_out);
        end else begin
          w = exp_wb.pop_front();
          check("wb_rd_en",    {31'b0, rd_en_out},    {31'b0, w.rd_en});
          check("wb_rd_addr",  {27'b0, rd_addr_out},  {27'b0, w.rd_addr});
          check("wb_rd_data",  rd_data_out,           w.rd_data);
          check("wb_misalign", {31'b0, misalign_out}, {31'b0, w.mis});
          check("wb_bus_err",  {31'b0, bus_err_out},  {31'b0, w.err});
        end
      end
      req_prev = dmem_req_out;
      wb_prev  = wb_valid_out;
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    mem_rdata = v.rdata;
    ack_delay = v.ack_dly;
    if (v.exp_req) exp_dmem.push_back('{v.exp_we, v.exp_daddr, v.exp_wstrb, v.exp_wdata, v.exp_len});
    exp_wb.push_back('{v.exp_rd_en, v.rd_addr, v.exp_rd_data, v.exp_mis, v.exp_err});
    check($sformatf("v%0d_ready", idx), {31'b0, req_ready_out}, 32'd1);
    req_valid_in  = 1'b1;
    addr_in       = v.addr;
    load_flag_in  = v.ld;
    store_flag_in = v.st;
    store_data_in = v.data;
    rd_en_in      = v.rd_en;
    rd_addr_in    = v.rd_addr;
    @(posedge clk); #1;
    req_valid_in  = 1'b0;
    addr_in       = '0;
    load_flag_in  = '0;
    store_flag_in = '0;
    store_data_in = '0;
    rd_en_in      = 1'b0;
    rd_addr_in    = '0;
    lat = 1;
    while (!wb_valid_out && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    // Cycles counted with the accept cycle as cycle 1.
    check($sformatf("v%0d_wb_cycle", idx), lat + 1, v.exp_cyc);
    @(posedge clk); #1;
  endtask

  initial begin
    //          ld        st       addr          data          en rd  dly rdata         req daddr         we wstrb    wdata         len en rd_data       mis err cyc
    vecs.push_back('{5'b00001, 4'b0000, 32'h0000_0001, 32'h0,        1, 1,  0, 32'h0000_7F00, 1, 32'h0000_0000, 0, 4'b0000, 32'h0,        1, 1, 32'h0000_007F, 0, 0, 3});
    vecs.push_back('{5'b00000, 4'b0001, 32'h0000_1003, 32'h0000_00A5, 1, 7,  3, 32'h0,        1, 32'h0000_1000, 1, 4'b1000, 32'hA5A5_A5A5, 4, 0, 32'h0,        0, 0, 6});
    vecs.push_back('{5'b00001, 4'b0000, 32'h0000_2002, 32'h0,        1, 3,  0, 32'h0080_0000, 1, 32'h0000_2000, 0, 4'b0000, 32'h0,        1, 1, 32'hFFFF_FF80, 0, 0, 3});
    vecs.push_back('{5'b01000, 4'b0000, 32'h0000_2002, 32'h0,        1, 3,  0, 32'h0080_0000, 1, 32'h0000_2000, 0, 4'b0000, 32'h0,        1, 1, 32'h0000_0080, 0, 0, 3});
    vecs.push_back('{5'b00010, 4'b0000, 32'h0000_3001, 32'h0,        1, 4,  0, 32'h0,        0, 32'h0,         0, 4'b0000, 32'h0,        0, 0, 32'h0,        1, 0, 2});
    vecs.push_back('{5'b00000, 4'b0000, 32'h1234_5678, 32'h0,        1, 5,  0, 32'h0,        0, 32'h0,         0, 4'b0000, 32'h0,        0, 1, 32'h1234_5678, 0, 0, 2});
    vecs.push_back('{5'b00000, 4'b0010, 32'h0000_5002, 32'hDEAD_BEEF, 1, 9,  1, 32'h0,        1, 32'h0000_5000, 1, 4'b1100, 32'hBEEF_BEEF, 2, 0, 32'h0,        0, 0, 4});
    vecs.push_back('{5'b00000, 4'b0100, 32'h0000_6000, 32'hCAFE_F00D, 1, 8,  0, 32'h0,        1, 32'h0000_6000, 1, 4'b1111, 32'hCAFE_F00D, 1, 0, 32'h0,        0, 0, 3});
    vecs.push_back('{5'b10000, 4'b0000, 32'h0000_7002, 32'h0,        1, 10, 2, 32'h8001_1234, 1, 32'h0000_7000, 0, 4'b0000, 32'h0,        3, 1, 32'h0000_8001, 0, 0, 5});
    vecs.push_back('{5'b00010, 4'b0000, 32'h0000_7002, 32'h0,        1, 11, 0, 32'h8001_1234, 1, 32'h0000_7000, 0, 4'b0000, 32'h0,        1, 1, 32'hFFFF_8001, 0, 0, 3});
    vecs.push_back('{5'b00100, 4'b0100, 32'h0000_8000, 32'hFFFF_FFFF, 1, 12, 0, 32'h1122_3344, 1, 32'h0000_8000, 0, 4'b0000, 32'h0,        1, 1, 32'h1122_3344, 0, 0, 3});
    vecs.push_back('{5'b00000, 4'b0100, 32'h0000_9002, 32'h1234_5678, 1, 13, 0, 32'h0,        0, 32'h0,         0, 4'b0000, 32'h0,        0, 0, 32'h0,        1, 0, 2});
    vecs.push_back('{5'b00100, 4'b0000, 32'h0000_A004, 32'h0,        0, 2,  0, 32'h55AA_55AA, 1, 32'h0000_A004, 0, 4'b0000, 32'h0,        1, 0, 32'h55AA_55AA, 0, 0, 3});
    vecs.push_back('{5'b00100, 4'b0000, 32'h0000_4000, 32'h0,        1, 6, -1, 32'h0,        1, 32'h0000_4000, 0, 4'b0000, 32'h0,      255, 0, 32'h0,        0, 1, 257});

    #3;
    check("rst_ready",    {31'b0, req_ready_out}, 32'd1);
    check("rst_dmem_req", {31'b0, dmem_req_out},  32'd0);
    check("rst_wb_valid", {31'b0, wb_valid_out},  32'd0);
    check("rst_rd_data",  rd_data_out,            32'd0);
    check("rst_dmem_addr", dmem_addr_out,         32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset while a load is waiting for its ack.
    ack_delay = -1;
    exp_dmem.push_back('{1'b0, 32'h0000_B000, 4'b0000, 32'h0, 3});
    req_valid_in = 1'b1;
    addr_in      = 32'h0000_B000;
    load_flag_in = 5'b00100;
    rd_en_in     = 1'b1;
    rd_addr_in   = 5'd14;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    load_flag_in = '0;
    check("abort_req_pending", {31'b0, dmem_req_out}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req_drop", {31'b0, dmem_req_out},  32'd0);
    check("abort_ready",    {31'b0, req_ready_out}, 32'd1);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    ack_force = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("late_ack_no_req", {31'b0, dmem_req_out}, 32'd0);
      check("late_ack_no_wb",  {31'b0, wb_valid_out}, 32'd0);
    end
    ack_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("exp_dmem_drained", exp_dmem.size(), 32'd0);
    check("exp_wb_drained",   exp_wb.size(),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_in  in  1  execute-stage op valid.
- req_ready_out  out  1  op accepted when high with req_valid_in.
- addr_in  in  XLEN  effective address, or ALU result for non-memory ops.
- load_flag_in  in  5  load type code.
- store_flag_in  in  4  store type code.
- store_data_in  in  XLEN  store source (rs2).
- rd_en_in  in  1  writeback enable.
- rd_addr_in  in  XREG_ADDRWIDTH  destination register.
- dmem_req_out  out  1  memory request.
- dmem_we_out  out  1  1 = write.
- dmem_addr_out  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wstrb_out  out  4  byte-lane write strobes.
- dmem_wdata_out  out  32  lane-positioned write data.
- dmem_ack_in  in  1  request completed; read data valid.
- dmem_rdata_in  in  32  read word.
- wb_valid_out  out  1  one-cycle writeback pulse.
- rd_en_out  out  1  writeback enable.
- rd_addr_out  out  XREG_ADDRWIDTH  destination register.
- rd_data_out  out  XLEN  writeback data.
- misalign_out  out  1  one-cycle misaligned-access pulse.
- bus_err_out  out  1  one-cycle timeout pulse.
REQ-002 SHALL use the shared-config flag codes:
- NO_LOAD=00000, LOAD_B=00001, LOAD_H=00010, LOAD_W=00100, LOAD_BU=01000, LOAD_HU=10000.
- NO_STORE=0000, STORE_B=0001, STORE_H=0010, STORE_W=0100.
REQ-003 SHALL expose parameter TIMEOUT, default 255: maximum wait cycles for dmem_ack_in.

Function
REQ-004 SHALL implement FSM IDLE, REQ, RESP; req_ready_out=1 only in IDLE.
REQ-005 SHALL capture all request inputs into internal registers on accept (IDLE, req_valid_in=1).
REQ-006 SHALL route an accepted op with both flags zero (non-memory op) IDLE->RESP, with rd_data_out=addr_in.
REQ-007 SHALL route an accepted aligned load or store IDLE->REQ.
REQ-008 SHALL give load priority when both flags are nonzero; the store is dropped.
REQ-009 SHALL treat an access as misaligned when H/HU has addr[0]=1, or W has addr[1:0]!=00.
REQ-010 SHALL handle a misaligned access as IDLE->RESP: no dmem_req_out, misalign_out=1 and rd_en_out=0 in RESP.
REQ-011 SHALL, in REQ, hold dmem_req_out=1 with addr, we, wstrb and wdata stable until dmem_ack_in; an ack in the first REQ cycle is valid.
REQ-012 SHALL ignore dmem_ack_in outside REQ.
REQ-013 SHALL, on ack, go REQ->RESP and register dmem_rdata_in for loads.
REQ-014 SHALL count REQ cycles; if the count reaches TIMEOUT without ack, go to RESP with bus_err_out=1, rd_en_out=0, dmem_req_out dropped.
REQ-015 SHALL, in RESP, assert wb_valid_out for exactly one cycle, then return to IDLE.
- rd_en_out = captured rd_en for loads/non-memory ops; 0 for stores and errors.
REQ-016 SHALL form store lanes as follows:
- B: wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0].
- H: wdata={2{d[15:0]}}, wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1).
- W: wdata=d, wstrb=1111.
- Loads: wstrb=0000, we=0.
REQ-017 SHALL extract load data by shifting rdata right by 8*addr[1:0], then applying B/H sign-extension or BU/HU zero-extension to XLEN; W passes through.
REQ-018 SHALL give minimum latency: non-memory ops 2 cycles accept-to-wb_valid; memory ops 2 cycles plus ack wait.

Reset
REQ-019 SHALL, with rst_n low, immediately force:
- FSM=IDLE, counter=0, all captured registers 0.
- dmem_req_out, dmem_we_out, wb_valid_out, rd_en_out, misalign_out, bus_err_out = 0.
- dmem_addr_out, dmem_wstrb_out, dmem_wdata_out, rd_addr_out, rd_data_out = 0.
REQ-020 SHALL abandon any reset asserted mid-REQ: the request drops the same instant, and a late ack after release is ignored per REQ-012.

Structure
REQ-021 SHALL take XLEN, XREG_ADDRWIDTH, the load/store flag codes, FSM state codes and the TIMEOUT default from the shared config header.
REQ-022 SHALL place lane/strobe generation and load extraction in the combinational sub-module lsu_align; the FSM, counter and registers live in lsu.

Verification
REQ-023 SHALL cover these directed scenarios:
- STORE_B, addr=0x1003, data=0x000000A5, ack after 3 cycles -> dmem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, wb_valid with rd_en_out=0.
- LOAD_B, addr=0x2002, rdata=0x00800000, immediate ack -> rd_data_out=0xFFFFFF80; same with LOAD_BU -> 0x00000080.
- LOAD_H, addr=0x3001 -> no dmem_req_out, misalign_out=1, rd_en_out=0, wb_valid 2 cycles after accept.
- Non-memory op, addr_in=0x12345678, rd_addr_in=5 -> wb_valid 2 cycles after accept, rd_data=0x12345678, rd_addr=5.
- LOAD_W, no ack -> bus_err_out after TIMEOUT=255 cycles; rst_n pulsed during a separate pending REQ -> dmem_req_out drops immediately, later ack ignored.
